// File: rtl/char_scroller_pkg.sv
// Shared glyph codes and active-low 7-segment table for the character scroller.
// Segment vectors are indexed bit 0 = a .. bit 6 = g.
package char_scroller_pkg;

  localparam logic [2:0] GLYPH_D     = 3'd0;
  localparam logic [2:0] GLYPH_E     = 3'd1;
  localparam logic [2:0] GLYPH_ONE   = 3'd2;
  localparam logic [2:0] GLYPH_BLANK = 3'd3;
  localparam logic [2:0] GLYPH_ZERO  = 3'd4;
  localparam logic [2:0] GLYPH_H     = 3'd5;
  localparam logic [2:0] GLYPH_L     = 3'd6;
  localparam logic [2:0] GLYPH_P     = 3'd7;

  // Bit i is segment i, so each entry reads g..a from left to right.
  localparam logic [6:0] SEG_TABLE [8] = '{
    7'b0100001,  // d
    7'b0000110,  // E
    7'b1111001,  // 1
    7'b1111111,  // blank
    7'b1000000,  // 0
    7'b0001001,  // H
    7'b1000111,  // L
    7'b0001100   // P
  };

  // Power-up message: d, E, 1, then blanks.
  function automatic logic [2:0] init_code(input int unsigned idx);
    case (idx)
      0:       return GLYPH_D;
      1:       return GLYPH_E;
      2:       return GLYPH_ONE;
      default: return GLYPH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Maps one 3-bit glyph code to its 7 active-low segments.
module seg7_glyph
  import char_scroller_pkg::*;
(
  input  logic [2:0] code_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[code_i];

endmodule

// File: rtl/char_scroller.sv
// Scrolling message across N_DIGITS 7-segment digits, auto or single-step.
// Optional macro CHAR_SCROLLER_BLINK_EN adds a blink input that blanks on alternate ticks.
module char_scroller
  import char_scroller_pkg::*;
#(
  parameter int unsigned N_DIGITS = 3,
  parameter int unsigned N_CHARS  = 4,
  parameter int unsigned TICK_DIV = 50000000,
  localparam int unsigned AW = (N_CHARS > 2) ? $clog2(N_CHARS) : 1
) (
  input  logic                  Clock,
  input  logic                  Resetn,
`ifdef CHAR_SCROLLER_BLINK_EN
  input  logic                  blink,
`endif
  input  logic                  enable,
  input  logic                  dir,
  input  logic                  step,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [2:0]            wr_code,
  output logic [7*N_DIGITS-1:0] hex,
  output logic [AW-1:0]         pos,
  output logic                  tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  function automatic logic [7*N_DIGITS-1:0] hex_reset();
    logic [7*N_DIGITS-1:0] v;
    v = '1;
    for (int unsigned j = 0; j < N_DIGITS; j++)
      v[7*j +: 7] = SEG_TABLE[init_code((N_DIGITS - 1 - j) % N_CHARS)];
    return v;
  endfunction

  localparam logic [7*N_DIGITS-1:0] HEX_RST = hex_reset();

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         pos_q, pos_d;
  logic                  step_q, step_prev_q;
  logic [2:0]            msg_q [N_CHARS];
  logic [7*N_DIGITS-1:0] hex_q, hex_d;
  logic [7*N_DIGITS-1:0] seg;
  logic                  run, blank, move, step_edge, wr_ok;

`ifdef CHAR_SCROLLER_BLINK_EN
  logic blank_q, blank_d;

  assign run     = enable | blink;
  assign blank   = blank_q;
  assign blank_d = blink ? (blank_q ^ tick) : 1'b0;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) blank_q <= 1'b0;
    else         blank_q <= blank_d;
  end
`else
  assign run   = enable;
  assign blank = 1'b0;
`endif

  // Gated by Resetn so tick is low during reset even when TICK_DIV is 1.
  assign tick  = Resetn && run && (cnt_q == CW'(TICK_DIV - 1));
  assign cnt_d = (!run || tick) ? '0 : cnt_q + CW'(1);

  assign step_edge = step_q & ~step_prev_q;
  assign move      = enable ? tick : step_edge;

  always_comb begin
    pos_d = pos_q;
    if (move) begin
      if (dir) pos_d = (pos_q == '0) ? AW'(N_CHARS - 1) : pos_q - AW'(1);
      else     pos_d = (pos_q == AW'(N_CHARS - 1)) ? '0 : pos_q + AW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q       <= '0;
      pos_q       <= '0;
      step_q      <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      step_q      <= step;
      step_prev_q <= step_q;
    end
  end

  assign wr_ok = (32'(wr_addr) < N_CHARS);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int unsigned i = 0; i < N_CHARS; i++) msg_q[i] <= init_code(i);
    end else if (wr_en && wr_ok) begin
      msg_q[wr_addr] <= wr_code;
    end
  end

  for (genvar j = 0; j < N_DIGITS; j++) begin : g_digit
    localparam int unsigned OFF = N_DIGITS - 1 - j;
    logic [AW-1:0] idx;

    assign idx = AW'((32'(pos_q) + OFF) % N_CHARS);

    seg7_glyph u_glyph (
      .code_i (msg_q[idx]),
      .seg_o  (seg[7*j +: 7])
    );
  end

  assign hex_d = blank ? '1 : seg;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) hex_q <= HEX_RST;
    else         hex_q <= hex_d;
  end

  assign hex = hex_q;
  assign pos = pos_q;

endmodule

// File: tb/tb_char_scroller.sv
// Directed self-checking bench for char_scroller (N_DIGITS=3, N_CHARS=4, TICK_DIV=4).
module tb_char_scroller;

  localparam logic [6:0] S_D  = 7'h21;
  localparam logic [6:0] S_E  = 7'h06;
  localparam logic [6:0] S_1  = 7'h79;
  localparam logic [6:0] S_BL = 7'h7F;
  localparam logic [6:0] S_H  = 7'h09;

  logic        Clock   = 1'b0;
  logic        Resetn  = 1'b0;
  logic        enable  = 1'b0;
  logic        dir     = 1'b0;
  logic        step    = 1'b0;
  logic        wr_en   = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [2:0]  wr_code = '0;
`ifdef CHAR_SCROLLER_BLINK_EN
  logic        blink   = 1'b0;
`endif
  logic [20:0] hex;
  logic [1:0]  pos;
  logic        tick;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  char_scroller #(
    .N_DIGITS (3),
    .N_CHARS  (4),
    .TICK_DIV (4)
  ) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
`ifdef CHAR_SCROLLER_BLINK_EN
    .blink   (blink),
`endif
    .enable  (enable),
    .dir     (dir),
    .step    (step),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_code (wr_code),
    .hex     (hex),
    .pos     (pos),
    .tick    (tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_hex",  32'(hex),  32'({S_D, S_E, S_1}));
    chk("rst_pos",  32'(pos),  32'd0);
    chk("rst_tick", 32'(tick), 32'd0);

    @(negedge Clock);
    Resetn = 1'b1;
    cyc(3);
    chk("idle_hex",  32'(hex),  32'({S_D, S_E, S_1}));
    chk("idle_pos",  32'(pos),  32'd0);
    chk("idle_tick", 32'(tick), 32'd0);

    // Forward auto-scroll.
    enable = 1'b1; dir = 1'b0;
    cyc(2); chk("fwd_notick", 32'(tick), 32'd0);
    cyc(1); chk("fwd_tick",   32'(tick), 32'd1);
            chk("fwd_pos0",   32'(pos),  32'd0);
    cyc(1); chk("fwd_pos1",   32'(pos),  32'd1);
            chk("fwd_hexlag", 32'(hex),  32'({S_D, S_E, S_1}));
    cyc(1); chk("fwd_hex1",   32'(hex),  32'({S_E, S_1, S_BL}));
    cyc(7); chk("fwd_pos3",   32'(pos),  32'd3);
    cyc(4); chk("fwd_wrap",   32'(pos),  32'd0);

    enable = 1'b0;
    cyc(5);
    chk("hold_pos",  32'(pos),  32'd0);
    chk("hold_tick", 32'(tick), 32'd0);

    // Reverse auto-scroll wraps 0 -> 3.
    enable = 1'b1; dir = 1'b1;
    cyc(4); chk("rev_pos", 32'(pos), 32'd3);
    cyc(1); chk("rev_hex", 32'(hex), 32'({S_BL, S_D, S_E}));
    enable = 1'b0; dir = 1'b0;
    cyc(2);

    // Held step moves once.
    step = 1'b1;
    cyc(10); chk("step_once", 32'(pos), 32'd0);
    step = 1'b0;
    cyc(2);  chk("step_after", 32'(pos), 32'd0);

    // Write concurrent with a tick.
    enable = 1'b1;
    cyc(3); chk("wr_tick", 32'(tick), 32'd1);
    wr_en = 1'b1; wr_addr = 2'd3; wr_code = 3'd5;
    cyc(1); wr_en = 1'b0;
            chk("wr_pos", 32'(pos), 32'd1);
    cyc(1); chk("wr_hex", 32'(hex), 32'({S_E, S_1, S_H}));

    // Asynchronous reset mid-count discards prescaler and writes.
    cyc(1);
    #2 Resetn = 1'b0;
    #1;
    chk("rst2_hex",  32'(hex),  32'({S_D, S_E, S_1}));
    chk("rst2_pos",  32'(pos),  32'd0);
    chk("rst2_tick", 32'(tick), 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    cyc(2); chk("rst2_notick", 32'(tick), 32'd0);
    cyc(1); chk("rst2_tick3",  32'(tick), 32'd1);
    cyc(1); chk("rst2_pos1",   32'(pos),  32'd1);
    cyc(1); chk("rst2_hex1",   32'(hex),  32'({S_E, S_1, S_BL}));
    enable = 1'b0;
    cyc(2);

`ifdef CHAR_SCROLLER_BLINK_EN
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    blink = 1'b1;
    cyc(3); chk("blk_tick",   32'(tick), 32'd1);
    cyc(2); chk("blk_blank1", 32'(hex),  32'({S_BL, S_BL, S_BL}));
    cyc(3); chk("blk_blank4", 32'(hex),  32'({S_BL, S_BL, S_BL}));
    cyc(1); chk("blk_text",   32'(hex),  32'({S_D, S_E, S_1}));
            chk("blk_pos",    32'(pos),  32'd0);
    blink = 1'b0;
    cyc(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/char_scroller.md
CHAR_SCROLLER -- requirements
Module: char_scroller

Interface
REQ-001 Parameter N_DIGITS, default 3: number of 7-segment digits driven, at least 1.
REQ-002 Parameter N_CHARS, default 4: message buffer length in characters, at least 2.
REQ-003 Parameter TICK_DIV, default 50000000: Clock cycles per scroll tick, at least 1.
REQ-004 Clock  input  1  system clock; all state SHALL change on its rising edge.
REQ-005 Resetn  input  1  reset, asynchronous and active-low.
REQ-006 enable  input  1  auto-scroll on ticks when 1.
REQ-007 dir  input  1  scroll direction: 0 advances pos, 1 retreats pos.
REQ-008 step  input  1  manual single-step request, acted on at its rising edge.
REQ-009 wr_en  input  1  message write strobe.
REQ-010 wr_addr  input  AW=max(1,$clog2(N_CHARS))  buffer index to write; index >= N_CHARS SHALL be ignored.
REQ-011 wr_code  input  3  glyph code to write.
REQ-012 hex  output  7*N_DIGITS  active-low segments; bit 7k+i = segment i (a=0..g=6) of digit k; digit 0 is rightmost.
REQ-013 pos  output  AW  current scroll offset.
REQ-014 tick  output  1  one-cycle pulse when the prescaler wraps.

Function
REQ-015 Glyph codes SHALL be: 0=d 1000010, 1=E 0110000, 2=1 1001111, 3=blank 1111111, 4=0 0000001, 5=H 1001000, 6=L 1110001, 7=P 0011000 (segments a..g, active-low).
REQ-016 Digit j SHALL display msg[(pos + N_DIGITS-1-j) mod N_CHARS]; with N_DIGITS > N_CHARS the message repeats.
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 while enable=1, assert tick in the cycle it equals TICK_DIV-1, and wrap to 0 on the next edge; it SHALL be held at 0 while enable=0.
REQ-018 On a tick edge pos SHALL become (pos+1) mod N_CHARS if dir=0, or (pos-1) mod N_CHARS if dir=1, wrapping between N_CHARS-1 and 0.
REQ-019 step SHALL be registered and edge-detected; a 0->1 transition SHALL move pos one place per dir only when enable=0, and is otherwise ignored.
REQ-020 A step held high SHALL produce exactly one move.
REQ-021 wr_en=1 SHALL write wr_code into msg[wr_addr] at the same edge; a write and a pos move in the same cycle SHALL both take effect.
REQ-022 hex SHALL be registered: it reflects pos and msg one cycle after they change.
REQ-023 A change of dir SHALL take effect at the next tick; no pos move SHALL occur without a tick or a step edge.

Reset
REQ-024 Resetn=0 SHALL immediately set pos=0, prescaler=0, step history=0, tick=0, msg=[0,1,2,3,3,...] (d,E,1,then blank), and hex to the glyphs of that message at pos=0.
REQ-025 Reset mid-scroll SHALL discard the partial prescaler count and all buffer writes.

Configuration
REQ-026 Macro CHAR_SCROLLER_BLINK_EN: when defined, input port blink (1 bit) exists. A blank-phase flag SHALL toggle on every tick while blink=1, and the prescaler SHALL run while enable or blink is 1. All digits SHALL show blank while the flag is 1. The flag SHALL clear when blink=0 or on reset.
REQ-027 Without CHAR_SCROLLER_BLINK_EN there is no blink port, and hex SHALL never be force-blanked.

Structure
REQ-028 Shared package char_scroller_pkg SHALL hold the 3-bit glyph code constants and the 8-entry active-low segment table.
REQ-029 Sub-module seg7_glyph SHALL map one 3-bit code to 7 segments, instantiated N_DIGITS times.

Verification (N_DIGITS=3, N_CHARS=4, TICK_DIV=4)
REQ-030 Reset release, enable=0 -> hex = {1000010,0110000,1001111} (left to right), pos=0, no tick.
REQ-031 enable=1, dir=0 for 4 cycles -> tick on cycle 4, pos=1, next cycle hex = E,1,blank; after 16 cycles pos wraps back to 0.
REQ-032 enable=1, dir=1 from pos=0 -> first tick gives pos=3, hex = blank,d,E.
REQ-033 enable=0, step held high 10 cycles -> pos advances exactly once.
REQ-034 wr_en with addr=3, code=5 in the same cycle as a tick taking pos from 0 to 1 -> next cycle hex = E,1,H.
REQ-035 BLINK_EN, blink=1, enable=0 -> hex is all 1111111 for 4 cycles after the 1st tick, text for 4 cycles after the 2nd tick, and pos stays 0.
